// File: rtl/snax_cgra_shell_pkg.sv
// Shared types and constants for the SNAX CGRA stream shell.
//   - shell_state_e : launch/run FSM encoding (also exported in the status CSR)
//   - ctrl_word_t   : decoded shell control word (last RW CSR)
//   - Ctrl*         : control-word field offsets/widths
//   - Ro*           : offsets of the shell RO words after the core RO words
package snax_cgra_shell_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONFIG = 2'd1,
        ST_RUN    = 2'd2
    } shell_state_e;

    localparam int unsigned CtrlTargetLsb  = 0;
    localparam int unsigned CtrlTargetW    = 16;
    localparam int unsigned CtrlInMaskLsb  = 16;
    localparam int unsigned CtrlOutMaskLsb = 24;
    localparam int unsigned CtrlMaskW      = 8;

    typedef struct packed {
        logic [CtrlMaskW-1:0]   out_mask;
        logic [CtrlMaskW-1:0]   in_mask;
        logic [CtrlTargetW-1:0] out_target;
    } ctrl_word_t;

    // Offsets relative to the first shell RO word.
    localparam int unsigned RoBusyCycles = 0;
    localparam int unsigned RoInBeats    = 1;
    localparam int unsigned RoOutBeats   = 2;
    localparam int unsigned RoStatus     = 3;
    localparam int unsigned NumShellRo   = 4;

    function automatic ctrl_word_t ctrl_decode(input logic [31:0] w);
        ctrl_word_t c;
        c.out_target = w[CtrlTargetLsb  +: CtrlTargetW];
        c.in_mask    = w[CtrlInMaskLsb  +: CtrlMaskW];
        c.out_mask   = w[CtrlOutMaskLsb +: CtrlMaskW];
        return c;
    endfunction

    // bit0 busy, bit1 done, bits[3:2] state
    function automatic logic [31:0] status_word(input shell_state_e st, input logic done);
        return {28'd0, st, done, st != ST_IDLE};
    endfunction

endpackage

// File: rtl/snax_cgra_stream_fifo.sv
// Per-channel elastic FIFO with valid/ready on both sides.
//   in_*  : push side (in_ready_o = !full, never depends on out_ready_i)
//   out_* : pop side  (out_valid_o = !empty, data registered)
// Push and pop may happen in the same cycle whenever not full, so Depth 2
// sustains one beat per cycle with one cycle of latency.
module snax_cgra_stream_fifo #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Depth-1:0][DataWidth-1:0] mem_q;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign in_ready_o  = (cnt_q != CntW'(Depth));
    assign out_valid_o = (cnt_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: an empty FIFO never presents its contents.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

endmodule

// File: rtl/snax_cgra_stream_shell.sv
// CGRA accelerator shell between the SNAX streamer and the CGRA core.
//   stream2acc_* -> per-channel FIFO -> core_recv_*   (input direction)
//   core_send_*  -> per-channel FIFO -> acc2stream_*  (output direction)
//   csr_reg_set_*     : RW CSR write; last word is the shell control word
//   core_csr_rw_*     : latched core config with valid/ack handshake
//   csr_reg_ro_set_o  : core RO words, then busy_cycles, in_beats,
//                       out_beats, status
// The FSM (IDLE -> CONFIG -> RUN -> IDLE) ends a run once the count of
// output beats reaches the programmed target.
module snax_cgra_stream_shell
    import snax_cgra_shell_pkg::*;
#(
    parameter int unsigned NumChIn      = 8,
    parameter int unsigned NumChOut     = 8,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned FifoDepth    = 2,
    parameter int unsigned NumCoreRwCsr = 37,
    parameter int unsigned NumCoreRoCsr = 8,
    parameter int unsigned NumRwCsr     = NumCoreRwCsr + 1,
    parameter int unsigned NumRoCsr     = NumCoreRoCsr + 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumChIn-1:0][DataWidth-1:0]     stream2acc_data_i,
    input  logic [NumChIn-1:0]                    stream2acc_valid_i,
    output logic [NumChIn-1:0]                    stream2acc_ready_o,
    output logic [NumChOut-1:0][DataWidth-1:0]    acc2stream_data_o,
    output logic [NumChOut-1:0]                   acc2stream_valid_o,
    input  logic [NumChOut-1:0]                   acc2stream_ready_i,
    input  logic [NumRwCsr-1:0][31:0]             csr_reg_set_i,
    input  logic                                  csr_reg_set_valid_i,
    output logic                                  csr_reg_set_ready_o,
    output logic [NumRoCsr-1:0][31:0]             csr_reg_ro_set_o,
    output logic [NumChIn-1:0][DataWidth-1:0]     core_recv_data_o,
    output logic [NumChIn-1:0]                    core_recv_en_o,
    input  logic [NumChIn-1:0]                    core_recv_rdy_i,
    input  logic [NumChOut-1:0][DataWidth-1:0]    core_send_data_i,
    input  logic [NumChOut-1:0]                   core_send_en_i,
    output logic [NumChOut-1:0]                   core_send_rdy_o,
    output logic [NumCoreRwCsr-1:0][31:0]         core_csr_rw_o,
    output logic                                  core_csr_rw_valid_o,
    input  logic                                  core_csr_rw_ack_i,
    input  logic [NumCoreRoCsr-1:0][31:0]         core_csr_ro_i
);

    // Masks come up all-ones so the data path works before any launch.
    localparam ctrl_word_t CtrlReset = ctrl_word_t'(32'hFFFF_0000);

    shell_state_e                 state_q, state_d;
    logic [NumCoreRwCsr-1:0][31:0] cfg_q, cfg_d;
    ctrl_word_t                   ctrl_q, ctrl_d;
    logic                         done_q, done_d;
    logic [31:0]                  busy_q, busy_d, in_q, in_d, out_q, out_d;

    logic [NumChIn-1:0]  in_en, in_hs;
    logic [NumChOut-1:0] out_en, out_hs;
    logic [31:0]         in_pop, out_pop;

    // ---------------- data path ----------------
    for (genvar c = 0; c < NumChIn; c++) begin : g_in
        logic fifo_rdy;
        // Channels beyond the mask width have no enable bit and stay on.
        if (c < int'(CtrlMaskW)) begin : g_mask
            assign in_en[c] = ctrl_q.in_mask[c];
        end else begin : g_nomask
            assign in_en[c] = 1'b1;
        end
        snax_cgra_stream_fifo #(.DataWidth(DataWidth), .Depth(FifoDepth)) i_fifo (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .in_data_i   (stream2acc_data_i[c]),
            .in_valid_i  (stream2acc_valid_i[c] & in_en[c]),
            .in_ready_o  (fifo_rdy),
            .out_data_o  (core_recv_data_o[c]),
            .out_valid_o (core_recv_en_o[c]),
            .out_ready_i (core_recv_rdy_i[c])
        );
        assign stream2acc_ready_o[c] = fifo_rdy & in_en[c];
    end

    for (genvar c = 0; c < NumChOut; c++) begin : g_out
        logic fifo_rdy;
        if (c < int'(CtrlMaskW)) begin : g_mask
            assign out_en[c] = ctrl_q.out_mask[c];
        end else begin : g_nomask
            assign out_en[c] = 1'b1;
        end
        snax_cgra_stream_fifo #(.DataWidth(DataWidth), .Depth(FifoDepth)) i_fifo (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .in_data_i   (core_send_data_i[c]),
            .in_valid_i  (core_send_en_i[c] & out_en[c]),
            .in_ready_o  (fifo_rdy),
            .out_data_o  (acc2stream_data_o[c]),
            .out_valid_o (acc2stream_valid_o[c]),
            .out_ready_i (acc2stream_ready_i[c])
        );
        assign core_send_rdy_o[c] = fifo_rdy & out_en[c];
    end

    assign in_hs  = stream2acc_valid_i & stream2acc_ready_o;
    assign out_hs = acc2stream_valid_o & acc2stream_ready_i;

    always_comb begin
        in_pop  = '0;
        out_pop = '0;
        for (int c = 0; c < NumChIn; c++)  in_pop  = in_pop  + 32'(in_hs[c]);
        for (int c = 0; c < NumChOut; c++) out_pop = out_pop + 32'(out_hs[c]);
    end

    // ---------------- counters ----------------
    always_comb begin
        busy_d = busy_q;
        in_d   = in_q;
        out_d  = out_q;
        if (state_q == ST_IDLE && csr_reg_set_valid_i) begin
            busy_d = '0;
            in_d   = '0;
            out_d  = '0;
        end else if (state_q == ST_RUN) begin
            if (busy_q != '1) busy_d = busy_q + 32'd1;
            in_d  = in_q + in_pop;
            out_d = out_q + out_pop;
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d             = state_q;
        cfg_d               = cfg_q;
        ctrl_d              = ctrl_q;
        done_d              = done_q;
        csr_reg_set_ready_o = 1'b0;
        core_csr_rw_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                csr_reg_set_ready_o = 1'b1;
                if (csr_reg_set_valid_i) begin
                    cfg_d   = csr_reg_set_i[NumCoreRwCsr-1:0];
                    ctrl_d  = ctrl_decode(csr_reg_set_i[NumRwCsr-1]);
                    done_d  = 1'b0;
                    state_d = ST_CONFIG;
                end
            end
            ST_CONFIG: begin
                core_csr_rw_valid_o = 1'b1;
                if (core_csr_rw_ack_i) begin
                    if (ctrl_q.out_target == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Compare the post-update count so completion lands in the
                // cycle of the final beat; several channels may overshoot.
                if (out_d >= 32'(ctrl_q.out_target)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            ctrl_q  <= CtrlReset;
            done_q  <= 1'b0;
            busy_q  <= '0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            ctrl_q  <= ctrl_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    // ---------------- CSR outputs ----------------
    assign core_csr_rw_o = cfg_q;

    assign csr_reg_ro_set_o[NumCoreRoCsr-1:0]            = core_csr_ro_i;
    assign csr_reg_ro_set_o[NumCoreRoCsr + RoBusyCycles] = busy_q;
    assign csr_reg_ro_set_o[NumCoreRoCsr + RoInBeats]    = in_q;
    assign csr_reg_ro_set_o[NumCoreRoCsr + RoOutBeats]   = out_q;
    assign csr_reg_ro_set_o[NumCoreRoCsr + RoStatus]     = status_word(state_q, done_q);

endmodule

// File: tb/tb_snax_cgra_stream_shell.sv
// Self-checking bench for snax_cgra_stream_shell: directed FSM/CSR checks
// plus a per-channel scoreboard on both stream directions.
module tb_snax_cgra_stream_shell;

    localparam int NumChIn      = 8;
    localparam int NumChOut     = 8;
    localparam int DataWidth    = 64;
    localparam int FifoDepth    = 2;
    localparam int NumCoreRwCsr = 37;
    localparam int NumCoreRoCsr = 8;
    localparam int NumRwCsr     = NumCoreRwCsr + 1;
    localparam int NumRoCsr     = NumCoreRoCsr + 4;
    localparam int RoBusy = NumCoreRoCsr, RoIn = NumCoreRoCsr + 1;
    localparam int RoOut  = NumCoreRoCsr + 2, RoStat = NumCoreRoCsr + 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NumChIn-1:0][DataWidth-1:0]  s2a_data;
    logic [NumChIn-1:0]                 s2a_valid;
    logic [NumChIn-1:0]                 stream2acc_ready_o;
    logic [NumChOut-1:0][DataWidth-1:0] acc2stream_data_o;
    logic [NumChOut-1:0]                acc2stream_valid_o;
    logic [NumChOut-1:0]                a2s_ready;
    logic [NumRwCsr-1:0][31:0]          csr_set;
    logic                               csr_valid;
    logic                               csr_reg_set_ready_o;
    logic [NumRoCsr-1:0][31:0]          ro;
    logic [NumChIn-1:0][DataWidth-1:0]  core_recv_data_o;
    logic [NumChIn-1:0]                 core_recv_en_o;
    logic [NumChIn-1:0]                 core_recv_rdy;
    logic [NumChOut-1:0][DataWidth-1:0] core_send_data;
    logic [NumChOut-1:0]                core_send_en;
    logic [NumChOut-1:0]                core_send_rdy_o;
    logic [NumCoreRwCsr-1:0][31:0]      core_csr_rw_o;
    logic                               core_csr_rw_valid_o;
    logic                               csr_ack;
    logic [NumCoreRoCsr-1:0][31:0]      core_ro;

    snax_cgra_stream_shell #(
        .NumChIn(NumChIn), .NumChOut(NumChOut), .DataWidth(DataWidth),
        .FifoDepth(FifoDepth), .NumCoreRwCsr(NumCoreRwCsr),
        .NumCoreRoCsr(NumCoreRoCsr), .NumRwCsr(NumRwCsr), .NumRoCsr(NumRoCsr)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .stream2acc_data_i(s2a_data), .stream2acc_valid_i(s2a_valid),
        .stream2acc_ready_o(stream2acc_ready_o),
        .acc2stream_data_o(acc2stream_data_o), .acc2stream_valid_o(acc2stream_valid_o),
        .acc2stream_ready_i(a2s_ready),
        .csr_reg_set_i(csr_set), .csr_reg_set_valid_i(csr_valid),
        .csr_reg_set_ready_o(csr_reg_set_ready_o), .csr_reg_ro_set_o(ro),
        .core_recv_data_o(core_recv_data_o), .core_recv_en_o(core_recv_en_o),
        .core_recv_rdy_i(core_recv_rdy),
        .core_send_data_i(core_send_data), .core_send_en_i(core_send_en),
        .core_send_rdy_o(core_send_rdy_o),
        .core_csr_rw_o(core_csr_rw_o), .core_csr_rw_valid_o(core_csr_rw_valid_o),
        .core_csr_rw_ack_i(csr_ack), .core_csr_ro_i(core_ro)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [DataWidth-1:0] q_in  [NumChIn][$];
    logic [DataWidth-1:0] q_out [NumChOut][$];
    logic [DataWidth-1:0] mon_exp;
    int out_hs_total = 0;

    // Sampled late in the low phase: inputs are settled and these are the
    // values the next rising edge acts on.
    always begin
        @(negedge clk); #3;
        if (!rst_n) begin
            for (int c = 0; c < NumChIn; c++)  q_in[c].delete();
            for (int c = 0; c < NumChOut; c++) q_out[c].delete();
        end else begin
            for (int c = 0; c < NumChIn; c++) begin
                if (s2a_valid[c] && stream2acc_ready_o[c]) q_in[c].push_back(s2a_data[c]);
                if (core_recv_en_o[c] && core_recv_rdy[c]) begin
                    if (q_in[c].size() != 0) mon_exp = q_in[c].pop_front();
                    else mon_exp = ~core_recv_data_o[c];
                    chk("in_path_data", core_recv_data_o[c], mon_exp);
                end
            end
            for (int c = 0; c < NumChOut; c++) begin
                if (core_send_en[c] && core_send_rdy_o[c]) q_out[c].push_back(core_send_data[c]);
                if (acc2stream_valid_o[c] && a2s_ready[c]) begin
                    out_hs_total++;
                    if (q_out[c].size() != 0) mon_exp = q_out[c].pop_front();
                    else mon_exp = ~acc2stream_data_o[c];
                    chk("out_path_data", acc2stream_data_o[c], mon_exp);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc();
        @(negedge clk); #1;
    endtask

    task automatic write_cfg(input logic [31:0] w, input logic [31:0] seed, input int ack_dly);
        int vcnt;
        vcnt = 0;
        cyc();
        for (int i = 0; i < NumCoreRwCsr; i++) csr_set[i] = seed + 32'(i);
        csr_set[NumRwCsr-1] = w;
        csr_valid = 1'b1;
        cyc();
        csr_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (core_csr_rw_valid_o) vcnt++;
            if (vcnt == ack_dly) begin
                csr_ack = 1'b1;
                cyc();
                csr_ack = 1'b0;
                break;
            end
            cyc();
        end
        chk("cfg_valid_cycles", 64'(vcnt), 64'(ack_dly));
        chk("cfg_valid_low", 64'(core_csr_rw_valid_o), 64'd0);
        chk("cfg_data", 64'(core_csr_rw_o[NumCoreRwCsr-1]), 64'(seed + 32'(NumCoreRwCsr - 1)));
    endtask

    // Stops driving core_send and waits until n output beats have been
    // seen since base; returns in the cycle of the n-th beat.
    task automatic wait_out(input int base, input int n);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            core_send_en = '0;
            #3;
            if (out_hs_total - base >= n) begin
                seen = 1'b1;
                break;
            end
        end
        chk("out_beats_seen", 64'(seen), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base, sent;
        logic [DataWidth-1:0] d1;
        rst_n = 1'b0;
        s2a_data = '0; s2a_valid = '0; a2s_ready = '1;
        csr_set = '0; csr_valid = 1'b0; csr_ack = 1'b0;
        core_recv_rdy = '0; core_send_data = '0; core_send_en = '0;
        for (int i = 0; i < NumCoreRoCsr; i++) core_ro[i] = 32'hCC00_0000 + 32'(i);
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        // reset state
        chk("rst_set_ready", 64'(csr_reg_set_ready_o), 64'd1);
        chk("rst_status", 64'(ro[RoStat]), 64'd0);
        chk("rst_recv_en", 64'(core_recv_en_o), 64'd0);
        chk("rst_acc_valid", 64'(acc2stream_valid_o), 64'd0);
        chk("rst_cfg_valid", 64'(core_csr_rw_valid_o), 64'd0);
        chk("rst_cfg_word", 64'(core_csr_rw_o[0]), 64'd0);
        chk("rst_in_ready", 64'(stream2acc_ready_o), 64'hFF);
        chk("rst_send_rdy", 64'(core_send_rdy_o), 64'hFF);
        chk("ro_core_pass0", 64'(ro[3]), 64'hCC00_0003);
        chk("ro_core_pass7", 64'(ro[NumCoreRoCsr-1]), 64'hCC00_0007);

        // run: target 4, masks 0x03, two beats on each of out ch0/ch1
        write_cfg(32'h0303_0004, 32'h1000_0000, 3);
        chk("run_status", 64'(ro[RoStat]), 64'd9);
        chk("run_set_ready", 64'(csr_reg_set_ready_o), 64'd0);
        base = out_hs_total;
        for (int k = 0; k < 2; k++) begin
            core_send_data[0] = {$urandom(), $urandom()};
            core_send_data[1] = {$urandom(), $urandom()};
            core_send_en = 8'h03;
            if (k == 0) cyc();
        end
        wait_out(base, 4);
        cyc();
        chk("run_done_status", 64'(ro[RoStat]), 64'd2);
        chk("run_out_beats", 64'(ro[RoOut]), 64'd4);
        chk("run_busy_cycles", 64'(ro[RoBusy]), 64'd3);
        chk("run_in_beats", 64'(ro[RoIn]), 64'd0);

        // input backpressure on ch0 (IDLE, in_mask 0x03 still latched)
        core_recv_rdy = '0;
        sent = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            s2a_data[0] = 64'hD000_0000_0000_0000 + 64'(sent);
            s2a_valid[0] = 1'b1;
            #1;
            if (stream2acc_ready_o[0]) sent++;
        end
        chk("bp_accepted", 64'(sent), 64'd2);
        chk("bp_ready_low", 64'(stream2acc_ready_o[0]), 64'd0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            core_recv_rdy[0] = 1'b1;
            s2a_data[0] = 64'hD000_0000_0000_0000 + 64'(sent);
            s2a_valid[0] = 1'b1;
            #1;
            if (stream2acc_ready_o[0]) sent++;
        end
        chk("bp_stream_total", 64'(sent), 64'd7);
        cyc();
        s2a_valid[0] = 1'b0;
        repeat (2) cyc();
        chk("bp_drained", 64'(q_in[0].size()), 64'd0);
        chk("idle_in_beats", 64'(ro[RoIn]), 64'd0);

        // one-cycle latency on ch1
        core_recv_rdy[1] = 1'b1;
        d1 = {$urandom(), $urandom()};
        s2a_data[1] = d1;
        s2a_valid[1] = 1'b1;
        cyc();
        s2a_valid[1] = 1'b0;
        chk("lat_en", 64'(core_recv_en_o[1]), 64'd1);
        chk("lat_data", core_recv_data_o[1], d1);
        cyc();
        chk("lat_en_after", 64'(core_recv_en_o[1]), 64'd0);

        // in_mask 0x01, out_mask 0, target 0 -> done right after ack
        write_cfg(32'h0001_0000, 32'h2000_0000, 1);
        chk("t0_status", 64'(ro[RoStat]), 64'd2);
        chk("t0_busy", 64'(ro[RoBusy]), 64'd0);
        chk("mask_in_ready", 64'(stream2acc_ready_o), 64'h01);
        chk("mask_send_rdy", 64'(core_send_rdy_o), 64'h00);
        core_recv_rdy = '1;
        for (int c = 0; c < NumChIn; c++) s2a_data[c] = {$urandom(), $urandom()};
        s2a_valid = '1;
        cyc();
        s2a_valid = '0;
        chk("mask_recv_en", 64'(core_recv_en_o), 64'h01);
        cyc();

        // all 8 outputs in one cycle, target 5 -> overshoot to 8
        write_cfg(32'hFFFF_0005, 32'h3000_0000, 1);
        base = out_hs_total;
        for (int c = 0; c < NumChOut; c++) core_send_data[c] = {$urandom(), $urandom()};
        core_send_en = '1;
        wait_out(base, 8);
        cyc();
        chk("ovs_status", 64'(ro[RoStat]), 64'd2);
        chk("ovs_out_beats", 64'(ro[RoOut]), 64'd8);
        chk("ovs_busy", 64'(ro[RoBusy]), 64'd2);

        // writes ignored in RUN, then reset with beats buffered
        write_cfg(32'hFFFF_0064, 32'h5000_0000, 2);
        for (int i = 0; i < NumCoreRwCsr; i++) csr_set[i] = 32'h7700_0000 + 32'(i);
        csr_valid = 1'b1;
        cyc();
        csr_valid = 1'b0;
        chk("ign_cfg_word", 64'(core_csr_rw_o[0]), 64'h5000_0000);
        chk("ign_status", 64'(ro[RoStat]), 64'd9);
        core_recv_rdy = '0;
        for (int k = 0; k < 2; k++) begin
            s2a_data[0] = {$urandom(), $urandom()};
            s2a_valid[0] = 1'b1;
            cyc();
        end
        s2a_valid[0] = 1'b0;
        chk("buf_in_beats", 64'(ro[RoIn]), 64'd2);
        chk("buf_recv_en", 64'(core_recv_en_o[0]), 64'd1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("mrst_recv_en", 64'(core_recv_en_o), 64'd0);
        chk("mrst_acc_valid", 64'(acc2stream_valid_o), 64'd0);
        chk("mrst_set_ready", 64'(csr_reg_set_ready_o), 64'd1);
        chk("mrst_status", 64'(ro[RoStat]), 64'd0);
        chk("mrst_in_beats", 64'(ro[RoIn]), 64'd0);
        chk("mrst_busy", 64'(ro[RoBusy]), 64'd0);
        chk("mrst_cfg_word", 64'(core_csr_rw_o[0]), 64'd0);
        chk("mrst_in_ready", 64'(stream2acc_ready_o), 64'hFF);
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snax_cgra_stream_shell.md
Name: snax_cgra_stream_shell

Overview:
Parametrised CGRA accelerator shell placed between the SNAX streamer and the CGRA core.
- Generalises channel count and data width through packed-array ports.
- Adds per-channel elastic FIFO buffering on both stream directions.
- Adds a CSR launch/run FSM with a beat-count completion condition.
- Exposes shell performance counters as extra RO CSRs appended after the core's RO CSRs.

Parameters:
- NumChIn, 8, streamer-to-core channels
- NumChOut, 8, core-to-streamer channels
- DataWidth, 64, bits per channel beat
- FifoDepth, 2, entries per channel FIFO (>=1)
- NumCoreRwCsr, 37, RW words forwarded to core
- NumCoreRoCsr, 8, RO words supplied by core
- NumRwCsr, NumCoreRwCsr+1, RW words; last word is shell control
- NumRoCsr, NumCoreRoCsr+4, RO words; last 4 are shell

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- stream2acc_data_i  in  [NumChIn][DataWidth]  streamer input data
- stream2acc_valid_i  in  [NumChIn]  input valid
- stream2acc_ready_o  out  [NumChIn]  input ready
- acc2stream_data_o  out  [NumChOut][DataWidth]  output data
- acc2stream_valid_o  out  [NumChOut]  output valid
- acc2stream_ready_i  in  [NumChOut]  output ready
- csr_reg_set_i  in  [NumRwCsr][32]  RW CSR words
- csr_reg_set_valid_i  in  1  RW write valid
- csr_reg_set_ready_o  out  1  RW write ready
- csr_reg_ro_set_o  out  [NumRoCsr][32]  RO CSR words
- core_recv_data_o  out  [NumChIn][DataWidth]  to core
- core_recv_en_o  out  [NumChIn]  to core, valid
- core_recv_rdy_i  in  [NumChIn]  from core
- core_send_data_i  in  [NumChOut][DataWidth]  from core
- core_send_en_i  in  [NumChOut]  from core, valid
- core_send_rdy_o  out  [NumChOut]  to core
- core_csr_rw_o  out  [NumCoreRwCsr][32]  latched config
- core_csr_rw_valid_o  out  1  config valid
- core_csr_rw_ack_i  in  1  core config accept
- core_csr_ro_i  in  [NumCoreRoCsr][32]  core RO words

Behaviour:
- Reset (rst_ni low at posedge):
  - FSM returns to IDLE; all FIFOs are flushed; counters, done and config registers clear to 0.
  - Resulting outputs: all valid/en outputs 0; csr_reg_set_ready_o 1; core_csr_rw_o 0.
  - Reset during CONFIG or RUN aborts the operation; no ack or data is retained.
- Control word W = csr_reg_set_i[NumRwCsr-1]:
  - [15:0] out_target: total output beats that end a run.
  - [23:16] in_mask, [31:24] out_mask: channel enables. Bits at or above the channel count are ignored.
- FSM:
  - IDLE: csr_reg_set_ready_o=1. On valid, latch core words and W, clear done and the three counters, then go to CONFIG.
  - CONFIG: core_csr_rw_valid_o=1 with stable latched data. On core_csr_rw_ack_i, go to RUN; if out_target==0, go to IDLE and set done instead.
  - RUN: csr_reg_set_ready_o=0 and incoming writes are ignored. When out_beats >= out_target, go to IDLE and set done.
- Data path, per channel, with a FIFO on each side:
  - Push when valid&ready; pop when core/stream valid&ready.
  - ready = !full; no combinational ready pass-through. A FIFO accepts push and pop in the same cycle whenever it is not full.
  - Latency is 1 cycle from the accept cycle to valid at the far side. Depth 2 sustains 1 beat/cycle/channel.
  - A channel with its mask bit 0 forces stream2acc_ready_o / core_send_rdy_o to 0; its contents are held.
  - Masks apply only after the first configuration. The reset mask is all-ones.
  - The data path is live in every state.
- Counters (counting only in RUN):
  - busy_cycles: 32b, saturating.
  - in_beats: 32b, wrapping; adds popcount of stream2acc handshakes per cycle.
  - out_beats: 32b, wrapping; adds popcount of acc2stream handshakes. Multi-channel overshoot is allowed, which is why completion uses >=.
- RO map:
  - words 0..NumCoreRoCsr-1 = core_csr_ro_i
  - then busy_cycles, in_beats, out_beats
  - then status: bit0 busy (state!=IDLE), bit1 done, bits[3:2] state encoding (IDLE=0, CONFIG=1, RUN=2)

Decomposition:
- Package snax_cgra_shell_pkg holds:
  - state enum
  - control-word field offsets and widths
  - RO index constants
- Sub-module snax_cgra_stream_fifo (parametrised DataWidth/Depth, valid/ready both sides, sync active-low reset).
  - Instantiated NumChIn+NumChOut times via generate.

Test Plan:
- Reset mid-RUN with 2 beats buffered -> next cycle all valids 0, csr_reg_set_ready_o=1, status=0, counters 0.
- Write W=0x0303_0004, core acks after 3 cycles -> core_csr_rw_valid_o high exactly 3 cycles, then RUN. Drive 2 beats each on out ch0/ch1 -> IDLE in the cycle after the 4th beat; out_beats=4, done=1.
- Input ch0 with stream valid held, core_recv_rdy_i=0 -> exactly 2 beats accepted, then stream2acc_ready_o[0]=0. Rdy high -> 1 beat/cycle with 1-cycle latency and data order preserved.
- in_mask=0x01 -> stream2acc_ready_o[7:1]=0 while ch0 flows; out_target=0 -> IDLE immediately after ack, done=1, busy_cycles=0.
- All 8 output channels fire in one cycle with out_target=5 -> out_beats=8, completion that cycle.
- csr_reg_set_valid_i pulsed during RUN -> ignored; latched core_csr_rw_o unchanged.
